dma_burst_responder: RTL and testbench
======================================

Name: dma_burst_responder

Overview:
- Responder (far end) of the DMA streamer request interface: accepts burst descriptors {addr, alen, size, strb} under a valid/ready handshake.
- Expands each accepted burst into per-beat address/strobe/last commands for the memory-side data path.
- Sits between the read/write streamers and the local memory port.
- Provides the `ready` the streamer waits on.

Parameters:
- ADDR_WIDTH, 32, request/beat address width.
- STRB_WIDTH, 64, byte strobes per beat (512-bit data path).
- REQ_FIFO_DEPTH, 2, pending request slots; power of two, ≥1.
- MAX_SIZE, 6, largest legal size encoding (2^6 = 64 bytes/beat).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid_i  in  1  burst request valid; held stable until accepted
- req_addr_i  in  ADDR_WIDTH  burst start byte address
- req_alen_i  in  8  beats minus one
- req_size_i  in  3  log2 bytes per beat
- req_strb_i  in  STRB_WIDTH  strobe applied to every beat
- req_ready_o  out  1  request accepted when valid&&ready
- beat_valid_o  out  1  beat command valid
- beat_addr_o  out  ADDR_WIDTH  beat byte address
- beat_strb_o  out  STRB_WIDTH  beat strobe
- beat_last_o  out  1  final beat of burst
- beat_ready_i  in  1  memory side consumes beat when valid&&ready
- busy_o  out  1  FIFO non-empty or burst in progress
- err_o  out  1  sticky protocol error (size > MAX_SIZE)

Behaviour:
- Reset: all outputs 0 except req_ready_o = 1 in the cycle after reset deasserts. FIFO pointers, beat counter, FSM → IDLE.
- Request handshake:
  - req_ready_o = !fifo_full, registered-state derived, no combinational path from req_valid_i.
  - Accept pushes {addr, alen, size, strb} into the FIFO.
- FSM states: IDLE, BURST.
  - IDLE: if FIFO non-empty, pop head into the active burst registers (beat_cnt = alen, cur_addr = addr, cur_size, cur_strb) → BURST. First beat is valid in the next cycle. Latency from accept (empty FIFO, IDLE) to beat_valid_o is 2 cycles.
  - BURST: beat_valid_o = 1; beat_addr_o = cur_addr; beat_last_o = (beat_cnt == 0).
    - On beat handshake with beat_cnt > 0: cur_addr += (1 << cur_size), modulo 2^ADDR_WIDTH; beat_cnt -= 1.
    - On the last beat handshake with FIFO non-empty: pop the next request in the same cycle and remain in BURST, so bursts are back-to-back with no bubble.
    - On the last beat handshake with FIFO empty: → IDLE.
  - beat_valid_o never drops while the beat is not accepted. addr, strb and last are stable while valid && !ready.
- Simultaneous push and pop:
  - On a full FIFO, the push is blocked because req_ready_o = 0 that cycle.
  - Pop-then-free takes effect the next cycle.
  - When the FIFO is neither full nor empty, push and pop in the same cycle keeps the count unchanged.
- Size error: if size > MAX_SIZE on accept, err_o is set (sticky until rst). The request is still executed with size clamped to MAX_SIZE.
- alen = 0: single beat, beat_last_o = 1 on the first beat.
- Address arithmetic: ADDR_WIDTH bits, wraps silently at 2^ADDR_WIDTH. INCR bursts only.
- busy_o = (state == BURST) || !fifo_empty.
- Reset mid-burst: burst and FIFO contents discarded, outputs return to reset values next cycle.

Optional Feature:
- Macro: DMA_RESP_4KB_CHK_EN.
- Defined:
  - On accept, compute end = addr + ((alen+1) << size) - 1. If end[ADDR_WIDTH-1:12] != addr[ADDR_WIDTH-1:12], set err_o (sticky).
  - The request is still executed unmodified.
- Undefined: no check logic; err_o reflects only the size error.

Decomposition:
- dma_pkg: s_dma_burst_req_t {addr, alen, size, strb}, resp_sm_t {IDLE, BURST}, constant DMA_4KB_SHIFT = 12.
  - Reuse axi_addr_t, axi_len_t, axi_size_t from axi_pkg.
- Sub-module dma_req_fifo:
  - Generic synchronous FIFO, parameterised by type and depth.
  - Ports: push/pop/full/empty/data.
  - Holds requests only; the beat FSM lives in the top module.

Test Plan:
- Single: addr 0x1000, alen 3, size 6, strb all-ones → 4 beats at 0x1000, 0x1040, 0x1080, 0x10C0; last on 4th; first beat 2 cycles after accept.
- Back-to-back: two requests (0x0 alen 0; 0x2000 alen 1), beat_ready_i = 1 → beats 0x0 (last), 0x2000, 0x2040 (last) on consecutive cycles, no bubble.
- Backpressure: beat_ready_i low 5 cycles mid-burst → beat_addr_o/last stable; FIFO fills after 2 more requests, req_ready_o = 0 until a pop.
- Error: size 7 → err_o = 1 next cycle, beats stride 64. With DMA_RESP_4KB_CHK_EN, addr 0x0FC0 alen 1 size 6 → err_o = 1.
- Wrap: addr 0xFFFF_FFC0 alen 1 size 6 → beats 0xFFFF_FFC0, 0x0000_0000.
- Reset mid-burst: rst at beat 2 of 8 → beat_valid_o = 0, busy_o = 0 next cycle; new request serviced normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI field types used by the DMA request path.
package axi_pkg;

   typedef logic [31:0] axi_addr_t;
   typedef logic [7:0]  axi_len_t;
   typedef logic [2:0]  axi_size_t;
   typedef logic [63:0] axi_strb_t;

endpackage

// File: rtl/dma_pkg.sv
// DMA burst responder types: request bundle, FSM states, size clamp helper.
package dma_pkg;

   import axi_pkg::*;

   localparam int DMA_4KB_SHIFT = 12;

   typedef struct packed {
      axi_addr_t addr;
      axi_len_t  alen;
      axi_size_t size;
      axi_strb_t strb;
   } s_dma_burst_req_t;

   typedef enum logic {
      IDLE,
      BURST
   } resp_sm_t;

   function automatic axi_size_t clamp_size(
      input axi_size_t s,
      input axi_size_t max_s
   );
      return (s > max_s) ? max_s : s;
   endfunction

endpackage

// File: rtl/dma_req_fifo.sv
// Generic synchronous FIFO holding pending burst requests.
module dma_req_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T               mem [DEPTH];
   logic [IW-1:0]  wr_idx;
   logic [IW-1:0]  rd_idx;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
      return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
   endfunction

   assign full_o  = (count == CW'(DEPTH));
   assign empty_o = (count == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_idx <= nxt(wr_idx);
         if (do_pop)  rd_idx <= nxt(rd_idx);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dma_burst_responder.sv
// Expands DMA burst descriptors into per-beat address/strobe/last commands.
// Optional 4KB boundary check: define DMA_RESP_4KB_CHK_EN.
module dma_burst_responder #(
   parameter int ADDR_WIDTH     = 32,
   parameter int STRB_WIDTH     = 64,
   parameter int REQ_FIFO_DEPTH = 2,
   parameter int MAX_SIZE       = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [7:0]            req_alen_i,
   input  logic [2:0]            req_size_i,
   input  logic [STRB_WIDTH-1:0] req_strb_i,
   output logic                  req_ready_o,
   output logic                  beat_valid_o,
   output logic [ADDR_WIDTH-1:0] beat_addr_o,
   output logic [STRB_WIDTH-1:0] beat_strb_o,
   output logic                  beat_last_o,
   input  logic                  beat_ready_i,
   output logic                  busy_o,
   output logic                  err_o
);

   import axi_pkg::*;
   import dma_pkg::*;

   localparam axi_size_t MAX_SZ = axi_size_t'(MAX_SIZE);

   s_dma_burst_req_t      push_req;
   s_dma_burst_req_t      head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   resp_sm_t              state_q;
   resp_sm_t              state_d;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [7:0]            beat_cnt;
   axi_size_t             cur_size;
   logic [STRB_WIDTH-1:0] cur_strb;
   logic                  err_q;
   logic                  beat_hs;
   logic                  size_err;
   logic                  bound_err;

   assign req_ready_o = !fifo_full;
   assign push        = req_valid_i && req_ready_o;
   assign size_err    = (req_size_i > MAX_SZ);

   // Oversized requests still run, stored with the clamped size.
   always_comb begin
      push_req      = '0;
      push_req.addr = axi_addr_t'(req_addr_i);
      push_req.alen = req_alen_i;
      push_req.size = clamp_size(req_size_i, MAX_SZ);
      push_req.strb = axi_strb_t'(req_strb_i);
   end

   dma_req_fifo #(
      .T     (s_dma_burst_req_t),
      .DEPTH (REQ_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_req),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef DMA_RESP_4KB_CHK_EN
   logic [ADDR_WIDTH-1:0] span;
   logic [ADDR_WIDTH-1:0] end_addr;

   assign span = (ADDR_WIDTH'(req_alen_i) + ADDR_WIDTH'(1))
                 << req_size_i;
   assign end_addr  = req_addr_i + span - ADDR_WIDTH'(1);
   assign bound_err =
      (end_addr[ADDR_WIDTH-1:DMA_4KB_SHIFT] !=
       req_addr_i[ADDR_WIDTH-1:DMA_4KB_SHIFT]);
`else
   assign bound_err = 1'b0;
`endif

   assign beat_hs = (state_q == BURST) && beat_ready_i;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            // Chain the next burst on the last beat: no bubble.
            if (beat_hs && (beat_cnt == '0)) begin
               if (!fifo_empty) pop = 1'b1;
               else state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr <= '0;
         beat_cnt <= '0;
         cur_size <= '0;
         cur_strb <= '0;
      end else if (pop) begin
         cur_addr <= ADDR_WIDTH'(head.addr);
         beat_cnt <= head.alen;
         cur_size <= head.size;
         cur_strb <= STRB_WIDTH'(head.strb);
      end else if (beat_hs) begin
         cur_addr <= cur_addr + (ADDR_WIDTH'(1) << cur_size);
         beat_cnt <= beat_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else if (push && (size_err || bound_err)) err_q <= 1'b1;
   end

   assign beat_valid_o = (state_q == BURST);
   assign beat_addr_o  = cur_addr;
   assign beat_strb_o  = cur_strb;
   assign beat_last_o  = (state_q == BURST) && (beat_cnt == '0);
   assign busy_o       = (state_q == BURST) || !fifo_empty;
   assign err_o        = err_q;

endmodule

// File: tb/tb_dma_burst_responder.sv
// Scoreboard bench for dma_burst_responder.
module tb_dma_burst_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [7:0]  req_alen;
   logic [2:0]  req_size;
   logic [63:0] req_strb;
   logic        req_ready_o;
   logic        beat_valid_o;
   logic [31:0] beat_addr_o;
   logic [63:0] beat_strb_o;
   logic        beat_last_o;
   logic        beat_ready;
   logic        busy_o;
   logic        err_o;

   typedef struct {
      logic [31:0] addr;
      logic        last;
      logic [63:0] strb;
   } beat_t;

   beat_t exp_q[$];
   int    beat_cyc_q[$];
   int    cyc = 0;
   int    acc_cyc = 0;
   int    n_beats = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   logic  exp_err;

   dma_burst_responder dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_addr_i   (req_addr),
      .req_alen_i   (req_alen),
      .req_size_i   (req_size),
      .req_strb_i   (req_strb),
      .req_ready_o  (req_ready_o),
      .beat_valid_o (beat_valid_o),
      .beat_addr_o  (beat_addr_o),
      .beat_strb_o  (beat_strb_o),
      .beat_last_o  (beat_last_o),
      .beat_ready_i (beat_ready),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (!rst && beat_valid_o && beat_ready) begin
         beat_t e;
         beat_cyc_q.push_back(cyc);
         n_beats++;
         if (exp_q.size() == 0) begin
            check("beat_q_size", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("beat_addr", 64'(beat_addr_o), 64'(e.addr));
            check("beat_last", 64'(beat_last_o), 64'(e.last));
            check("beat_strb", beat_strb_o, e.strb);
         end
      end
   end

   task automatic send(input logic [31:0] a,
                       input logic [7:0]  l,
                       input logic [2:0]  s,
                       input logic [63:0] st);
      logic [2:0]  se;
      logic [31:0] ba;
      int          k;
      se = (s > 3'd6) ? 3'd6 : s;
      ba = a;
      for (int i = 0; i <= int'(l); i++) begin
         exp_q.push_back('{addr: ba, last: (i == int'(l)), strb: st});
         ba = ba + (32'd1 << se);
      end
      req_valid = 1'b1;
      req_addr  = a;
      req_alen  = l;
      req_size  = s;
      req_strb  = st;
      k = 0;
      while (!req_ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("req_ready", 64'(req_ready_o), 64'd1);
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy_o) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      check("drain_busy", 64'(busy_o), 64'd0);
   endtask

   task automatic wait_beats(input int target);
      int k;
      k = 0;
      while (n_beats < target && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("beat_wait", 64'(n_beats >= target), 64'd1);
   endtask

   task automatic stall_chk();
      check("stall_valid", 64'(beat_valid_o), 64'd1);
      check("stall_addr", 64'(beat_addr_o), 64'(exp_q[0].addr));
      check("stall_last", 64'(beat_last_o), 64'(exp_q[0].last));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
`ifdef DMA_RESP_4KB_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_alen   = '0;
      req_size   = '0;
      req_strb   = '0;
      beat_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(req_ready_o), 64'd1);
      check("rst_valid", 64'(beat_valid_o), 64'd0);
      check("rst_last", 64'(beat_last_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);

      // single burst and first-beat latency
      beat_cyc_q.delete();
      send(32'h1000, 8'd3, 3'd6, '1);
      drain();
      check("single_nbeats", 64'(beat_cyc_q.size()), 64'd4);
      if (beat_cyc_q.size() > 0)
         check("first_lat", 64'(beat_cyc_q[0] - acc_cyc), 64'd2);

      // back-to-back bursts
      beat_cyc_q.delete();
      send(32'h0, 8'd0, 3'd6, 64'hFFFF_0000_FFFF_0000);
      send(32'h2000, 8'd1, 3'd6, 64'h0123_4567_89AB_CDEF);
      drain();
      check("b2b_nbeats", 64'(beat_cyc_q.size()), 64'd3);
      if (beat_cyc_q.size() == 3) begin
         check("b2b_gap0", 64'(beat_cyc_q[1] - beat_cyc_q[0]), 64'd1);
         check("b2b_gap1", 64'(beat_cyc_q[2] - beat_cyc_q[1]), 64'd1);
      end

      // backpressure and FIFO full
      send(32'h4000, 8'd7, 3'd6, '1);
      wait_beats(n_beats + 2);
      beat_ready = 1'b0;
      stall_chk();
      @(negedge clk);
      stall_chk();
      send(32'h5000, 8'd0, 3'd3, 64'hFF);
      stall_chk();
      send(32'h6000, 8'd1, 3'd2, 64'hF);
      check("full_ready", 64'(req_ready_o), 64'd0);
      check("full_busy", 64'(busy_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         stall_chk();
         @(negedge clk);
      end
      beat_ready = 1'b1;
      drain();
      check("refill_ready", 64'(req_ready_o), 64'd1);
      check("err_clean", 64'(err_o), 64'd0);

      // 4KB boundary crossing
      send(32'h0FC0, 8'd1, 3'd6, '1);
      check("err_4kb", 64'(err_o), 64'(exp_err));
      drain();

      // address wrap
      send(32'hFFFF_FFC0, 8'd1, 3'd6, 64'hAAAA);
      drain();

      // oversize request
      send(32'h8000, 8'd2, 3'd7, 64'hFFFF);
      check("err_size", 64'(err_o), 64'd1);
      drain();

      // reset mid-burst
      send(32'h9000, 8'd7, 3'd6, '1);
      wait_beats(n_beats + 2);
      rst        = 1'b1;
      beat_ready = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mrst_valid", 64'(beat_valid_o), 64'd0);
      check("mrst_busy", 64'(busy_o), 64'd0);
      check("mrst_err", 64'(err_o), 64'd0);
      rst        = 1'b0;
      beat_ready = 1'b1;
      @(negedge clk);
      check("mrst_ready", 64'(req_ready_o), 64'd1);
      send(32'hA000, 8'd1, 3'd5, 64'hFFFF_FFFF);
      drain();
      check("post_err", 64'(err_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
